alu_issue_stage: RTL

Registered issue stage that feeds the 32-bit ALU. Accepts a decoded-register-read instruction bundle (instruction word, PC, rs1/rs2 data) over a valid/ready handshake, selects and formats the two ALU operands, and generates the 4-bit ALU opcode `{funct7[5], funct3}`. It also emits the destination register and an illegal flag. It sits between register read and execute and provides one pipeline register of latency with full-throughput backpressure and flush.

---
 rtl/alu_issue_stage.sv | 107 ++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I ALU operand/opcode decode with a registered valid/ready issue stage.
// Define ALU_ISSUE_SKID_EN for a 2-entry skid buffer with a registered instr_ready_out.
module alu_issue_stage (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        flush_in,
  input  logic        instr_valid_in,
  output logic        instr_ready_out,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] rs1_data_in,
  input  logic [31:0] rs2_data_in,
  output logic        issue_valid_out,
  input  logic        issue_ready_in,
  output logic [31:0] op_1_out,
  output logic [31:0] op_2_out,
  output logic [3:0]  opcode_out,
  output logic [4:0]  rd_addr_out,
  output logic        illegal_out
);
  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  opc;
    logic [4:0]  rd;
    logic        ill;
  } bundle_t;
  bundle_t dec, out_q, out_d;
  logic out_v_q, out_v_d, acc, shift;
  logic [6:0] f7;
  logic [2:0] f3;
  logic [4:0] rd;
  logic [31:0] i_imm, s_imm, u_imm;
  assign f7 = instr_in[31:25];
  assign f3 = instr_in[14:12];
  assign rd = instr_in[11:7];
  assign i_imm = {{20{instr_in[31]}}, instr_in[31:20]};
  assign s_imm = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
  assign u_imm = {instr_in[31:12], 12'b0};
  assign shift = f3 == 3'd1 || f3 == 3'd5;
  always_comb begin
    dec = '{32'b0, 32'b0, 4'b0, 5'b0, 1'b1};
    case (instr_in[6:0])
      7'b0110011: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))
        dec = '{rs1_data_in, rs2_data_in, {f7[5], f3}, rd, 1'b0};
      7'b0010011: if (!shift || f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd5))
        dec = '{rs1_data_in, shift ? {27'b0, instr_in[24:20]} : i_imm, {f3 == 3'd5 && f7[5], f3}, rd, 1'b0};
      7'b0110111: dec = '{32'b0, u_imm, 4'b0, rd, 1'b0};
      7'b0010111: dec = '{pc_in, u_imm, 4'b0, rd, 1'b0};
      7'b1101111, 7'b1100111: dec = '{pc_in, 32'd4, 4'b0, rd, 1'b0};
      7'b0000011: dec = '{rs1_data_in, i_imm, 4'b0, rd, 1'b0};
      7'b0100011: dec = '{rs1_data_in, s_imm, 4'b0, 5'b0, 1'b0};
      default: ;
    endcase
  end
`ifdef ALU_ISSUE_SKID_EN
  bundle_t skd_q, skd_d;
  logic skd_v_q, skd_v_d;
  assign instr_ready_out = !skd_v_q;
  // The skid entry always drains into the output register before new input is taken.
  always_comb begin
    acc = instr_valid_in && !skd_v_q;
    out_d = out_q;
    out_v_d = out_v_q;
    skd_d = skd_q;
    skd_v_d = skd_v_q;
    if (flush_in) begin
      out_d = '0;
      out_v_d = 1'b0;
      skd_d = '0;
      skd_v_d = 1'b0;
    end else if (!out_v_q || issue_ready_in) begin
      out_v_d = skd_v_q || acc;
      out_d = skd_v_q ? skd_q : acc ? dec : out_q;
      skd_v_d = 1'b0;
    end else if (acc) begin
      skd_d = dec;
      skd_v_d = 1'b1;
    end
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      skd_q <= '0;
      skd_v_q <= 1'b0;
    end else begin
      skd_q <= skd_d;
      skd_v_q <= skd_v_d;
    end
`else
  assign instr_ready_out = !out_v_q || issue_ready_in;
  always_comb begin
    acc = instr_valid_in && instr_ready_out;
    out_v_d = !flush_in && (acc || (out_v_q && !issue_ready_in));
    out_d = flush_in ? '0 : acc ? dec : out_q;
  end
`endif
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      out_q <= '0;
      out_v_q <= 1'b0;
    end else begin
      out_q <= out_d;
      out_v_q <= out_v_d;
    end
  assign issue_valid_out = out_v_q;
  assign {op_1_out, op_2_out, opcode_out, rd_addr_out, illegal_out} = out_q;
endmodule
